// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the control-flow path of the 16-bit core.
//   - opcode encodings of the control-flow instructions
//   - branch condition-code encodings (instruction bits [11:9])
//   - bit positions of Z/V/N on the ALU flag bus
//   - pc_state_t: program-counter state machine states
package cpu_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_control_if.sv
// pc_control_if: bundle between the ID stage / ALU and the PC unit.
//   master modport: decode side, drives the ID-stage instruction fields,
//                   stall and the flag bus; observes the fetch address,
//                   flush, halt and the taken-branch count.
//   slave modport:  pc_control side (mirror image).
interface pc_control_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [2:0]       id_cond;
    logic [8:0]       id_imm9;
    logic [15:0]      id_rs_data;
    logic [15:0]      id_pc_plus2;
    logic [2:0]       Flags;
    logic [15:0]      pc;
    logic [15:0]      pc_plus2;
    logic             flush;
    logic             halt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, id_valid, id_opcode, id_cond, id_imm9,
               id_rs_data, id_pc_plus2, Flags,
        input  pc, pc_plus2, flush, halt, taken_cnt
    );

    modport slave (
        input  stall, id_valid, id_opcode, id_cond, id_imm9,
               id_rs_data, id_pc_plus2, Flags,
        output pc, pc_plus2, flush, halt, taken_cnt
    );

endinterface

// File: rtl/pc_control_branch_cond.sv
// branch_cond: purely combinational branch-condition evaluator.
//   cond      in  3  condition field of the branch instruction
//   Flags     in  3  ALU flag bus (Z=bit2, V=bit1, N=bit0)
//   cond_true out 1  condition holds for the given flags
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] Flags,
    output logic       cond_true
);

    logic z, v, n;

    always_comb begin
        z = Flags[FLAG_Z];
        v = Flags[FLAG_V];
        n = Flags[FLAG_N];
        cond_true = 1'b0;
        case (cond)
            CC_NE:   cond_true = ~z;
            CC_EQ:   cond_true = z;
            CC_GT:   cond_true = ~z & ~n;
            CC_LT:   cond_true = n;
            CC_GE:   cond_true = z | (~z & ~n);
            CC_LE:   cond_true = n | z;
            CC_OV:   cond_true = v;
            CC_UNC:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// pc_control: program counter and branch resolution for the 16-bit core.
// Owns the PC register, the RUN/HALTED state machine and a saturating
// taken-branch counter.
//   clk, rst    clock and asynchronous active-high reset
//   bus (slave) ID-stage instruction fields, stall and ALU flags in;
//               pc, pc_plus2, flush, halt and taken_cnt out
module pc_control
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    pc_control_if.slave bus
);

    pc_state_t        state;
    logic [15:0]      pc_q;
    logic             halt_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cond_true;
    logic             accept;
    logic             is_branch;
    logic             take;
    logic             hlt_go;
    logic [15:0]      pc_inc;
    logic [15:0]      b_target;
    logic [15:0]      target;

    branch_cond u_branch_cond (
        .cond      (bus.id_cond),
        .Flags     (bus.Flags),
        .cond_true (cond_true)
    );

    always_comb begin
        // An ID instruction only acts when it is real, not stalled, and the
        // core is still running.
        accept    = bus.id_valid & ~bus.stall & (state == RUN);
        is_branch = (bus.id_opcode == OP_B) | (bus.id_opcode == OP_BR);
        take      = accept & is_branch & cond_true;
        hlt_go    = accept & (bus.id_opcode == OP_HLT);
        // Natural 16-bit wrap takes 16'hFFFE to 16'h0000.
        pc_inc    = pc_q + 16'd2;
        // Word offset: sign-extend imm9 and scale by 2; sum wraps mod 2^16.
        b_target  = bus.id_pc_plus2 + {{6{bus.id_imm9[8]}}, bus.id_imm9, 1'b0};
        target    = (bus.id_opcode == OP_BR) ? bus.id_rs_data : b_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            pc_q   <= RESET_PC;
            halt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hlt_go) begin
                        // PC holds on the halt edge; the younger fetch is flushed.
                        state  <= HALTED;
                        halt_q <= 1'b1;
                    end else if (bus.stall) begin
                        pc_q <= pc_q;
                    end else if (take) begin
                        pc_q <= target;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pc_q <= pc_inc;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halt_q <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halt_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus2  = pc_inc;
    assign bus.flush     = take | hlt_go;
    assign bus.halt      = halt_q;
    assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: self-checking bench for pc_control.
// Two instances share one stimulus stream: a 16-bit counter build and a
// 2-bit counter build used for saturation. Expected post-edge state is
// pushed to a scoreboard queue when stimulus is driven and popped after
// the edge.
module tb_pc_control;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_control_if #(.CNT_W(16)) bus ();
    pc_control_if #(.CNT_W(2))  bus2 ();

    pc_control #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    pc_control #(.RESET_PC(16'h0000), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    assign bus2.stall       = bus.stall;
    assign bus2.id_valid    = bus.id_valid;
    assign bus2.id_opcode   = bus.id_opcode;
    assign bus2.id_cond     = bus.id_cond;
    assign bus2.id_imm9     = bus.id_imm9;
    assign bus2.id_rs_data  = bus.id_rs_data;
    assign bus2.id_pc_plus2 = bus.id_pc_plus2;
    assign bus2.Flags       = bus.Flags;

    typedef struct {
        logic [15:0] pc;
        logic        halt;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_pc;
    int          exp_cnt;

    function automatic logic cond_model(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] sat2(input int c);
        return (c >= 3) ? 2'd3 : 2'(c);
    endfunction

    task automatic drive(input logic st, input logic vld, input logic [3:0] op,
                         input logic [2:0] cc, input logic [8:0] imm,
                         input logic [15:0] rs, input logic [15:0] pcp2,
                         input logic [2:0] fl);
        bus.stall       = st;
        bus.id_valid    = vld;
        bus.id_opcode   = op;
        bus.id_cond     = cc;
        bus.id_imm9     = imm;
        bus.id_rs_data  = rs;
        bus.id_pc_plus2 = pcp2;
        bus.Flags       = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 4'h0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc  = 16'h0000;
        exp_cnt = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 4'h0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000);
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.pc, bus.pc_plus2, bus.halt, bus.flush, bus.taken_cnt} !==
            {16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000})
            begin
            n_fail++;
            $display("FAIL reset_values: pc=%h pc_plus2=%h halt=%b flush=%b cnt=%h, expected 0000 0002 0 0 0000",
                     bus.pc, bus.pc_plus2, bus.halt, bus.flush, bus.taken_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 16'h0000;
        sb.push_back('{16'h0000, 1'b0, 16'h0000, 2'd0});
        #1;
        e = sb.pop_front();
        n_tests++;
        if (bus.pc !== e.pc) begin
            n_fail++;
            $display("FAIL free_run_pc0: pc=%h expected %h", bus.pc, e.pc);
        end
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{16'(2 * i), 1'b0, 16'h0000, 2'd0});
            n_tests++;
            if (bus.flush !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run_flush: flush=%b expected 0", bus.flush);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.halt, e.cnt, e.cnt2}) begin
                n_fail++;
                $display("FAIL free_run_state: pc/halt/cnt/cnt2=%h/%b/%h/%h expected %h/%b/%h/%h",
                         bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt, e.pc, e.halt, e.cnt, e.cnt2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch(input logic [2:0] fl, input logic exp_take,
                               input logic [15:0] exp_next);
        do_reset();
        drive(0, 1, OP_B, CC_EQ, 9'h1FE, 16'h0, 16'h0010, fl);
        #1;
        n_tests++;
        if (bus.flush !== exp_take) begin
            n_fail++;
            $display("FAIL b_eq_flush: flags=%b flush=%b expected %b", fl, bus.flush, exp_take);
        end
        sb.push_back('{exp_next, 1'b0, 16'(exp_take), 2'(exp_take)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.halt, e.cnt, e.cnt2}) begin
            n_fail++;
            $display("FAIL b_eq_state: flags=%b pc/halt/cnt/cnt2=%h/%b/%h/%h expected %h/%b/%h/%h",
                     fl, bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt, e.pc, e.halt, e.cnt, e.cnt2);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic        st [0:5];
        logic        vld[0:5];
        logic [3:0]  op [0:5];
        logic        xf [0:5];
        logic [15:0] xpc[0:5];
        int          xc [0:5];
        do_reset();
        // stall, stall, go (BR taken), stall+HLT, invalid BR, HLT-less idle
        st  = '{1, 1, 0, 1, 0, 0};
        vld = '{1, 1, 1, 1, 0, 0};
        op  = '{OP_BR, OP_BR, OP_BR, OP_HLT, OP_BR, 4'h0};
        xf  = '{0, 0, 1, 0, 0, 0};
        xpc = '{16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'h1236, 16'h1238};
        xc  = '{0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            drive(st[i], vld[i], op[i], CC_UNC, 9'h0, 16'h1234, 16'h0, 3'b000);
            #1;
            n_tests++;
            if (bus.flush !== xf[i]) begin
                n_fail++;
                $display("FAIL stall_flush[%0d]: flush=%b expected %b", i, bus.flush, xf[i]);
            end
            sb.push_back('{xpc[i], 1'b0, 16'(xc[i]), sat2(xc[i])});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.halt, e.cnt, e.cnt2}) begin
                n_fail++;
                $display("FAIL stall_state[%0d]: pc/halt/cnt/cnt2=%h/%b/%h/%h expected %h/%b/%h/%h",
                         i, bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt, e.pc, e.halt, e.cnt, e.cnt2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 1, OP_BR, CC_UNC, 9'h0, 16'h0040, 16'h0, 3'b000);
        sb.push_back('{16'h0040, 1'b0, 16'd1, 2'd1});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({bus.pc, bus.halt} !== {e.pc, e.halt}) begin
            n_fail++;
            $display("FAIL halt_setup: pc/halt=%h/%b expected %h/%b", bus.pc, bus.halt, e.pc, e.halt);
        end
        @(negedge clk);
        drive(0, 1, OP_HLT, CC_UNC, 9'h0, 16'h0, 16'h0, 3'b000);
        #1;
        n_tests++;
        if ({bus.flush, bus.halt} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_accept: flush/halt=%b/%b expected 1/0", bus.flush, bus.halt);
        end
        sb.push_back('{16'h0040, 1'b1, 16'd1, 2'd1});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.halt, e.cnt, e.cnt2}) begin
            n_fail++;
            $display("FAIL halt_edge: pc/halt/cnt/cnt2=%h/%b/%h/%h expected %h/%b/%h/%h",
                     bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt, e.pc, e.halt, e.cnt, e.cnt2);
        end
        @(negedge clk);
        // A taken branch presented while halted must be ignored.
        drive(0, 1, OP_BR, CC_UNC, 9'h0, 16'h5555, 16'h0, 3'b000);
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if (bus.flush !== 1'b0) begin
                n_fail++;
                $display("FAIL halted_flush[%0d]: flush=%b expected 0", i, bus.flush);
            end
            sb.push_back('{16'h0040, 1'b1, 16'd1, 2'd1});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.halt, e.cnt, e.cnt2}) begin
                n_fail++;
                $display("FAIL halted_hold[%0d]: pc/halt/cnt/cnt2=%h/%b/%h/%h expected %h/%b/%h/%h",
                         i, bus.pc, bus.halt, bus.taken_cnt, bus2.taken_cnt, e.pc, e.halt, e.cnt, e.cnt2);
            end
            @(negedge clk);
        end
        drive(0, 0, 4'h0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.pc, bus.halt, bus.taken_cnt} !== {16'h0000, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset: pc/halt/cnt=%h/%b/%h expected 0000/0/0000",
                     bus.pc, bus.halt, bus.taken_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{16'h0002, 1'b0, 16'd0, 2'd0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({bus.pc, bus.halt} !== {e.pc, e.halt}) begin
            n_fail++;
            $display("FAIL post_halt_run: pc/halt=%h/%b expected %h/%b", bus.pc, bus.halt, e.pc, e.halt);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, OP_BR, CC_UNC, 9'h0, 16'(16'h0100 + 16 * i), 16'h0, 3'b000);
            sb.push_back('{16'(16'h0100 + 16 * i), 1'b0, 16'(i + 1), sat2(i + 1)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.pc, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.cnt, e.cnt2}) begin
                n_fail++;
                $display("FAIL saturate[%0d]: pc/cnt/cnt2=%h/%h/%h expected %h/%h/%h",
                         i, bus.pc, bus.taken_cnt, bus2.taken_cnt, e.pc, e.cnt, e.cnt2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 1, OP_BR, CC_UNC, 9'h0, 16'hFFFE, 16'h0, 3'b000);
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus.pc, bus.pc_plus2} !== {16'hFFFE, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_setup: pc/pc_plus2=%h/%h expected FFFE/0000", bus.pc, bus.pc_plus2);
        end
        @(negedge clk);
        drive(0, 0, 4'h0, 3'd0, 9'h0, 16'h0, 16'h0, 3'b000);
        sb.push_back('{16'h0000, 1'b0, 16'd1, 2'd1});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({bus.pc, bus.taken_cnt} !== {e.pc, e.cnt}) begin
            n_fail++;
            $display("FAIL wrap: pc/cnt=%h/%h expected %h/%h", bus.pc, bus.taken_cnt, e.pc, e.cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_cond_sweep();
        logic t;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                drive(0, 1, OP_B, 3'(c), 9'h010, 16'h0, 16'h0200, 3'(f));
                t = cond_model(3'(c), 3'(f));
                #1;
                n_tests++;
                if (bus.flush !== t) begin
                    n_fail++;
                    $display("FAIL cond_flush c=%0d f=%b: flush=%b expected %b", c, f, bus.flush, t);
                end
                exp_pc  = t ? 16'h0220 : exp_pc + 16'd2;
                exp_cnt = exp_cnt + int'(t);
                sb.push_back('{exp_pc, 1'b0, 16'(exp_cnt), sat2(exp_cnt)});
                @(posedge clk);
                #1;
                e = sb.pop_front();
                n_tests++;
                if ({bus.pc, bus.taken_cnt, bus2.taken_cnt} !== {e.pc, e.cnt, e.cnt2}) begin
                    n_fail++;
                    $display("FAIL cond_state c=%0d f=%b: pc/cnt/cnt2=%h/%h/%h expected %h/%h/%h",
                             c, f, bus.pc, bus.taken_cnt, bus2.taken_cnt, e.pc, e.cnt, e.cnt2);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_branch(3'b100, 1'b1, 16'h000C);
        test_branch(3'b000, 1'b0, 16'h0002);
        test_stall();
        test_halt();
        test_saturation();
        test_wrap();
        test_cond_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
